// File: rtl/param_interval_timer.sv
// Multi-channel interval timer with a 16-bit register interface.
// Each channel has a down-counter that reloads from its period register,
// a sticky timeout flag with an optional interrupt, and a snapshot register
// that captures the live count for coherent reads of wide counters.
module param_interval_timer #(
    parameter int NUM_CH         = 2,
    parameter int CNT_W          = 32,
    parameter int DEFAULT_PERIOD = 2499,
    localparam int CH_W          = (NUM_CH > 2) ? $clog2(NUM_CH) : 1,
    localparam int ADDR_W        = CH_W + 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
    output logic [NUM_CH-1:0] irq,
    output logic              irq_any
);

    // Channel slots cover every decodable channel index; slots past NUM_CH read 0.
    localparam int NUM_SLOT = 1 << CH_W;
    localparam logic [CNT_W-1:0] RESET_PERIOD = CNT_W'(DEFAULT_PERIOD);

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD_L = 3'd2;
    localparam logic [2:0] REG_PERIOD_H = 3'd3;
    localparam logic [2:0] REG_SNAP_L   = 3'd4;
    localparam logic [2:0] REG_SNAP_H   = 3'd5;

    logic [CH_W-1:0] ch_sel;
    logic [2:0]      reg_sel;
    logic            wr_strobe;
    logic [15:0]     rd_slot [NUM_SLOT];

    assign ch_sel    = address[ADDR_W-1:3];
    assign reg_sel   = address[2:0];
    assign wr_strobe = chipselect & ~write_n;

    for (genvar i = 0; i < NUM_SLOT; i++) begin : g_ch
        if (i < NUM_CH) begin : g_live
            logic [CNT_W-1:0] period;
            logic [CNT_W-1:0] per_next;
            logic [CNT_W-1:0] counter;
            logic [CNT_W-1:0] snapshot;
            logic [3:0]       control;
            logic             run;
            logic             to_flag;
            logic             zero_d;
            logic             force_reload;
            logic             ch_wr;
            logic             wr_status;
            logic             wr_control;
            logic             wr_per_l;
            logic             wr_per_h;
            logic             wr_snap;
            logic             start;
            logic             stop;
            logic             at_zero;
            logic             timeout_evt;
            logic [31:0]      per_wide;
            logic [31:0]      snap_wide;
            logic [31:0]      per_rd_wide;
            logic [15:0]      rd_val;

            assign ch_wr       = wr_strobe && (ch_sel == CH_W'(i));
            assign wr_status   = ch_wr && (reg_sel == REG_STATUS);
            assign wr_control  = ch_wr && (reg_sel == REG_CONTROL);
            assign wr_per_l    = ch_wr && (reg_sel == REG_PERIOD_L);
            assign wr_per_h    = ch_wr && (reg_sel == REG_PERIOD_H);
            assign wr_snap     = ch_wr && ((reg_sel == REG_SNAP_L) || (reg_sel == REG_SNAP_H));
            assign start       = wr_control & writedata[2];
            assign stop        = wr_control & writedata[3];
            assign at_zero     = (counter == '0);
            assign timeout_evt = at_zero & ~zero_d;

            // Merge period half-word writes through a 32-bit view so narrow
            // counters simply drop the bits they do not have.
            always_comb begin
                per_wide = 32'(period);
                if (wr_per_l) per_wide[15:0]  = writedata;
                if (wr_per_h) per_wide[31:16] = writedata;
                per_next = per_wide[CNT_W-1:0];
            end

            // Configuration registers: period, control and snapshot capture.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    period       <= RESET_PERIOD;
                    control      <= '0;
                    snapshot     <= '0;
                    force_reload <= 1'b0;
                end else begin
                    period       <= per_next;
                    force_reload <= wr_per_l | wr_per_h;
                    if (wr_control) control  <= writedata[3:0];
                    if (wr_snap)    snapshot <= counter;
                end
            end

            // Down-counter with reload on terminal count or after a period write.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    counter <= RESET_PERIOD;
                end else if (force_reload || (run && at_zero)) begin
                    counter <= period;
                end else if (run) begin
                    counter <= counter - CNT_W'(1);
                end
            end

            // RUN flag: START beats every clear source arriving in the same cycle.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    run <= 1'b0;
                end else if (start) begin
                    run <= 1'b1;
                end else if (stop || force_reload || (at_zero && !control[1])) begin
                    run <= 1'b0;
                end
            end

            // Timeout detection on the rising edge of the zero condition; a
            // status write clears TO and beats a coincident timeout.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    zero_d  <= 1'b0;
                    to_flag <= 1'b0;
                end else begin
                    zero_d <= at_zero;
                    if (wr_status) begin
                        to_flag <= 1'b0;
                    end else if (timeout_evt) begin
                        to_flag <= 1'b1;
                    end
                end
            end

            // Per-channel read view of the addressed register.
            always_comb begin
                snap_wide   = 32'(snapshot);
                per_rd_wide = 32'(period);
                rd_val      = '0;
                case (reg_sel)
                    REG_STATUS:   rd_val = {14'd0, run, to_flag};
                    REG_CONTROL:  rd_val = {12'd0, control};
                    REG_PERIOD_L: rd_val = per_rd_wide[15:0];
                    REG_PERIOD_H: rd_val = per_rd_wide[31:16];
                    REG_SNAP_L:   rd_val = snap_wide[15:0];
                    REG_SNAP_H:   rd_val = snap_wide[31:16];
                    default:      rd_val = '0;
                endcase
            end

            assign rd_slot[i] = rd_val;
            assign irq[i]     = to_flag & control[0];
        end else begin : g_absent
            assign rd_slot[i] = '0;
        end
    end

    // Registered read port: one cycle latency, independent of chipselect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_slot[ch_sel];
        end
    end

    assign irq_any = |irq;

endmodule

// File: tb/tb_param_interval_timer.sv
// Self-checking bench for param_interval_timer: directed scenarios on a
// 2-channel/32-bit instance and a 3-channel/12-bit instance, then random
// bus traffic on the 32-bit instance against a behavioural model.
module tb_param_interval_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  addr;
    logic        cs_a, cs_b, wn;
    logic [15:0] wd;
    logic [15:0] rd_a, rd_b;
    logic [1:0]  irq_a;
    logic [2:0]  irq_b;
    logic        any_a, any_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_interval_timer #(.NUM_CH(2), .CNT_W(32), .DEFAULT_PERIOD(2499)) dut_a (
        .clk(clk), .reset(rst), .address(addr[3:0]), .chipselect(cs_a),
        .write_n(wn), .writedata(wd), .readdata(rd_a), .irq(irq_a), .irq_any(any_a)
    );

    param_interval_timer #(.NUM_CH(3), .CNT_W(12), .DEFAULT_PERIOD(2499)) dut_b (
        .clk(clk), .reset(rst), .address(addr), .chipselect(cs_b),
        .write_n(wn), .writedata(wd), .readdata(rd_b), .irq(irq_b), .irq_any(any_b)
    );

    // Behavioural model of dut_a (two channels, 32-bit counters).
    bit [31:0] m_per  [2];
    bit [31:0] m_cnt  [2];
    bit [31:0] m_snap [2];
    bit [3:0]  m_ctl  [2];
    bit        m_run  [2];
    bit        m_to   [2];
    bit        m_zp   [2];
    bit        m_fr   [2];
    bit [15:0] m_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_per[c]  = 2499;
            m_cnt[c]  = 2499;
            m_snap[c] = 0;
            m_ctl[c]  = 0;
            m_run[c]  = 0;
            m_to[c]   = 0;
            m_zp[c]   = 0;
            m_fr[c]   = 0;
        end
        m_rd = 0;
    endfunction

    // One clock of the model; every rule reads the pre-edge state.
    function automatic void model_clock();
        bit wr;
        int ch;
        int rg;
        wr = cs_a && !wn;
        ch = int'(addr[3]);
        rg = int'(addr[2:0]);
        case (rg)
            0: m_rd = 16'({m_run[ch], m_to[ch]});
            1: m_rd = 16'(m_ctl[ch]);
            2: m_rd = m_per[ch][15:0];
            3: m_rd = m_per[ch][31:16];
            4: m_rd = m_snap[ch][15:0];
            5: m_rd = m_snap[ch][31:16];
            default: m_rd = 0;
        endcase
        for (int c = 0; c < 2; c++) begin
            bit mine;
            bit zero;
            bit start;
            bit stop;
            mine  = wr && (ch == c);
            zero  = (m_cnt[c] == 0);
            start = mine && (rg == 1) && wd[2];
            stop  = mine && (rg == 1) && wd[3];
            if (mine && rg == 0) m_to[c] = 0;
            else if (zero && !m_zp[c]) m_to[c] = 1;
            m_zp[c] = zero;
            if (mine && (rg == 4 || rg == 5)) m_snap[c] = m_cnt[c];
            if (m_fr[c] || (m_run[c] && zero)) m_cnt[c] = m_per[c];
            else if (m_run[c]) m_cnt[c] = m_cnt[c] - 1;
            if (start) m_run[c] = 1;
            else if (stop || m_fr[c] || (zero && !m_ctl[c][1])) m_run[c] = 0;
            m_fr[c] = mine && (rg == 2 || rg == 3);
            if (mine && rg == 1) m_ctl[c] = wd[3:0];
            if (mine && rg == 2) m_per[c][15:0] = wd;
            if (mine && rg == 3) m_per[c][31:16] = wd;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_clock();
        #1;
        check("rd_a", rd_a, m_rd);
        check("irq_a", irq_a, {m_to[1] & m_ctl[1][0], m_to[0] & m_ctl[0][0]});
        check("irq_any_a", any_a, (m_to[1] & m_ctl[1][0]) | (m_to[0] & m_ctl[0][0]));
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic bus_wr(input bit to_b, input logic [4:0] a, input logic [15:0] d);
        addr = a;
        wd   = d;
        wn   = 1'b0;
        cs_a = !to_b;
        cs_b = to_b;
        step();
        cs_a = 1'b0;
        cs_b = 1'b0;
        wn   = 1'b1;
    endtask

    task automatic bus_rd(input logic [4:0] a);
        addr = a;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [3:0]  ra;
        logic [15:0] rdat;

        rst = 1'b1; cs_a = 1'b0; cs_b = 1'b0; wn = 1'b1; wd = '0; addr = '0;
        model_reset();
        #1;
        check("rst_rd_a", rd_a, 0);
        check("rst_irq_a", irq_a, 0);
        check("rst_any_a", any_a, 0);
        check("rst_rd_b", rd_b, 0);
        check("rst_irq_b", irq_b, 0);
        idle(2);
        @(negedge clk) rst = 1'b0;

        bus_rd(5'd2);
        check("rst_period_l", rd_a, 2499);

        // Continuous timeouts on ch0 every 10 clocks
        bus_wr(0, 5'd2, 16'd9);
        bus_wr(0, 5'd3, 16'd0);
        bus_wr(0, 5'd1, 16'h7);
        idle(9);
        check("ch0_before_to", irq_a[0], 0);
        idle(1);
        check("ch0_first_to", irq_a[0], 1);
        check("ch0_irq_any", any_a, 1);
        check("ch1_unaffected", irq_a[1], 0);
        bus_wr(0, 5'd0, 16'd0);
        idle(8);
        check("ch0_gap", irq_a[0], 0);
        idle(1);
        check("ch0_second_to", irq_a[0], 1);

        // Status clear coinciding with the timeout edge wins
        bus_wr(0, 5'd0, 16'd0);
        idle(8);
        check("ch0_cleared", irq_a[0], 0);
        bus_wr(0, 5'd0, 16'd0);
        check("clear_wins", irq_a[0], 0);
        idle(9);
        check("clear_wins_gap", irq_a[0], 0);
        idle(1);
        check("clear_wins_next_to", irq_a[0], 1);

        // One-shot on ch1, period 3
        bus_wr(0, 5'd10, 16'd3);
        bus_wr(0, 5'd11, 16'd0);
        bus_wr(0, 5'd9, 16'h5);
        idle(3);
        check("oneshot_early", irq_a[1], 0);
        idle(1);
        check("oneshot_to", irq_a[1], 1);
        bus_rd(5'd8);
        check("oneshot_status", rd_a, 16'h0001);
        bus_wr(0, 5'd12, 16'd0);
        bus_rd(5'd12);
        check("oneshot_hold", rd_a, 3);

        // Snapshot of a count that spans both halves
        bus_wr(0, 5'd10, 16'h0004);
        bus_wr(0, 5'd11, 16'h0001);
        bus_wr(0, 5'd9, 16'h6);
        idle(5);
        bus_wr(0, 5'd12, 16'd0);
        bus_rd(5'd12);
        check("snap_l", rd_a, 16'hFFFF);
        bus_rd(5'd13);
        check("snap_h", rd_a, 16'h0000);

        // 12-bit, 3-channel instance
        bus_wr(1, 5'd2, 16'd5);
        bus_wr(1, 5'd1, 16'h6);
        idle(1);
        bus_rd(5'd0);
        check("b_running", rd_b, 16'h0002);
        bus_wr(1, 5'd3, 16'hFFFF);
        idle(1);
        bus_rd(5'd0);
        check("b_run_cleared", rd_b, 16'h0000);
        bus_rd(5'd2);
        check("b_period_l", rd_b, 5);
        bus_rd(5'd3);
        check("b_period_h", rd_b, 0);
        bus_wr(1, 5'd4, 16'd0);
        bus_rd(5'd4);
        check("b_reloaded", rd_b, 5);
        bus_rd(5'd26);
        check("b_ch3_reads_0", rd_b, 0);
        bus_rd(5'd6);
        check("b_reg6_reads_0", rd_b, 0);
        bus_rd(5'd18);
        check("b_ch2_period", rd_b, 2499);

        // Reset in the middle of counting with TO set
        check("pre_reset_any", any_a, 1);
        #3 rst = 1'b1;
        model_reset();
        #1;
        check("async_rd_a", rd_a, 0);
        check("async_irq_a", irq_a, 0);
        check("async_any_a", any_a, 0);
        check("async_rd_b", rd_b, 0);
        idle(2);
        @(negedge clk) rst = 1'b0;
        bus_rd(5'd2);
        check("post_rst_period_l", rd_a, 2499);
        bus_rd(5'd3);
        check("post_rst_period_h", rd_a, 0);
        idle(20);
        bus_wr(0, 5'd4, 16'd0);
        bus_rd(5'd4);
        check("post_rst_idle", rd_a, 2499);
        bus_rd(5'd0);
        check("post_rst_status", rd_a, 0);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            r    = $urandom_range(0, 9);
            ra   = 4'($urandom_range(0, 15));
            rdat = 16'($urandom);
            if (ra[2:0] == 3'd2) rdat = 16'($urandom_range(0, 24));
            if (ra[2:0] == 3'd3) rdat = ($urandom_range(0, 15) == 0) ? 16'd1 : 16'd0;
            addr = {1'b0, ra};
            wd   = rdat;
            cs_a = (r <= 3);
            wn   = !(r <= 2 || r == 4);
            step();
        end
        cs_a = 1'b0;
        wn   = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
